// File: rtl/iir_coeff_loader.sv
// Coefficient loader for the notch chain: gathers config words into per-filter shadow
// banks, commits a complete bank during a sample gap and verifies the filter readback.
module iir_coeff_loader #(
   parameter int COEFF_WIDTH     = 20,
   parameter int NUM_COEFF_DEPTH = 3,
   parameter int DEN_COEFF_DEPTH = 2,
   parameter int COEFF_DEPTH     = NUM_COEFF_DEPTH + DEN_COEFF_DEPTH,
   parameter int IDX_WIDTH       = 3,
   parameter int GAP_TIMEOUT     = 64,
   parameter int VERIFY_LAT      = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               cfg_valid,
   output logic                               cfg_ready,
   input  logic                               cfg_sel,
   input  logic [IDX_WIDTH-1:0]               cfg_idx,
   input  logic [COEFF_WIDTH-1:0]             cfg_data,
   input  logic                               cfg_last,
   input  logic                               sample_valid,
   output logic                               coeff_wr_en_1MHz,
   output logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_wdata_1MHz,
   input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_rdbk_1MHz,
   output logic                               coeff_wr_en_2_4MHz,
   output logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_wdata_2_4MHz,
   input  logic [COEFF_WIDTH*COEFF_DEPTH-1:0] coeff_rdbk_2_4MHz,
   output logic                               busy,
   output logic                               done,
   output logic [3:0]                         err,
   input  logic                               err_clr
);

   localparam int BANK_W = COEFF_WIDTH * COEFF_DEPTH;
   localparam int CNT_W  = $clog2(GAP_TIMEOUT + VERIFY_LAT + 1);
   localparam logic [IDX_WIDTH:0] IDX_LIMIT = (IDX_WIDTH+1)'(COEFF_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GAP,
      COMMIT,
      VERIFY
   } state_t;

   state_t                                       state_q, state_d;
   logic                                         target_q, target_d;
   logic [CNT_W-1:0]                             cnt_q, cnt_d;
   logic [1:0][COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] shadow_q, shadow_d;
   logic [1:0][COEFF_DEPTH-1:0]                  mask_q, mask_d;
   logic                                         wr_en_1m_q, wr_en_1m_d;
   logic                                         wr_en_2m4_q, wr_en_2m4_d;
   logic                                         done_q, done_d;
   logic                                         busy_q, busy_d;
   logic                                         ready_q, ready_d;
   logic [3:0]                                   err_q, err_d;

   logic                                         accept;
   logic                                         idx_ok;
   logic [COEFF_DEPTH-1:0]                       sel_mask;
   logic [CNT_W-1:0]                             cnt_inc;
   logic [BANK_W-1:0]                            rdbk_sel;

   // ready_q resets to 1 so the loader accepts in the very first cycle after rst drops
   assign cfg_ready          = ready_q & ~rst;
   assign coeff_wr_en_1MHz   = wr_en_1m_q;
   assign coeff_wr_en_2_4MHz = wr_en_2m4_q;
   assign coeff_wdata_1MHz   = shadow_q[0];
   assign coeff_wdata_2_4MHz = shadow_q[1];
   assign busy               = busy_q;
   assign done               = done_q;
   assign err                = err_q;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      mask_d   = mask_q;
      done_d   = 1'b0;
      err_d    = err_clr ? '0 : err_q;
      accept   = cfg_valid && cfg_ready;
      idx_ok   = {1'b0, cfg_idx} < IDX_LIMIT;
      sel_mask = mask_q[cfg_sel];
      cnt_inc  = cnt_q + 1'b1;
      rdbk_sel = target_q ? coeff_rdbk_2_4MHz : coeff_rdbk_1MHz;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (idx_ok) begin
                  for (int unsigned i = 0; i < COEFF_DEPTH; i++) begin
                     if (cfg_idx == IDX_WIDTH'(i)) begin
                        shadow_d[cfg_sel][i] = cfg_data;
                        sel_mask[i]          = 1'b1;
                     end
                  end
                  mask_d[cfg_sel] = sel_mask;
                  if (cfg_last) begin
                     if (&sel_mask) begin
                        state_d  = WAIT_GAP;
                        target_d = cfg_sel;
                        cnt_d    = '0;
                     end else begin
                        err_d[1]        = 1'b1;
                        mask_d[cfg_sel] = '0;
                     end
                  end
               end else begin
                  err_d[0] = 1'b1;
               end
            end
         end
         WAIT_GAP: begin
            if (!sample_valid) begin
               state_d = COMMIT;
            end else if (cnt_inc == CNT_W'(GAP_TIMEOUT)) begin
               err_d[2]         = 1'b1;
               mask_d[target_q] = '0;
               state_d          = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         COMMIT: begin
            mask_d[target_q] = '0;
            state_d          = VERIFY;
            cnt_d            = '0;
         end
         VERIFY: begin
            if (cnt_q == CNT_W'(VERIFY_LAT - 1)) begin
               if (rdbk_sel != shadow_q[target_q]) begin
                  err_d[3] = 1'b1;
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase

      // strobes are registered, so they are decoded from the state being entered
      wr_en_1m_d  = (state_d == COMMIT) && !target_d;
      wr_en_2m4_d = (state_d == COMMIT) && target_d;
      busy_d      = (state_d != IDLE);
      ready_d     = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         target_q    <= 1'b0;
         cnt_q       <= '0;
         shadow_q    <= '0;
         mask_q      <= '0;
         wr_en_1m_q  <= 1'b0;
         wr_en_2m4_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b1;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         mask_q      <= mask_d;
         wr_en_1m_q  <= wr_en_1m_d;
         wr_en_2m4_q <= wr_en_2m4_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Bench for iir_coeff_loader: directed and random coefficient loads checked against
// a bank/mask/error model and a capture-on-strobe model of both notch filters.
module tb_iir_coeff_loader;

   localparam int W    = 20;
   localparam int D    = 5;
   localparam int BANK = W * D;
   localparam logic [BANK-1:0] W2_MASK = {20'h0, 20'h0, 20'hFFFFF, 20'h0, 20'h0};

   logic            clk = 1'b0, rst = 1'b1;
   logic            cfg_valid = 1'b0, cfg_sel = 1'b0, cfg_last = 1'b0;
   logic            sample_valid = 1'b0, err_clr = 1'b0;
   logic [2:0]      cfg_idx = '0;
   logic [W-1:0]    cfg_data = '0;
   logic            cfg_ready, coeff_wr_en_1MHz, coeff_wr_en_2_4MHz, busy, done;
   logic [BANK-1:0] coeff_wdata_1MHz, coeff_wdata_2_4MHz, rdbk1, rdbk2;
   logic [BANK-1:0] fb1 = '0, fb2 = '0;
   logic [3:0]      err;
   bit              corrupt2 = 1'b0;

   logic [W-1:0]    sh_m [2][D];
   logic [D-1:0]    mk_m [2];
   logic [3:0]      err_m;
   logic [W-1:0]    spec_w [D];
   int              vectors = 0, miscompares = 0;

   iir_coeff_loader #(
      .COEFF_WIDTH(W), .NUM_COEFF_DEPTH(3), .DEN_COEFF_DEPTH(2), .IDX_WIDTH(3),
      .GAP_TIMEOUT(64), .VERIFY_LAT(1)
   ) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_last(cfg_last),
      .sample_valid(sample_valid),
      .coeff_wr_en_1MHz(coeff_wr_en_1MHz), .coeff_wdata_1MHz(coeff_wdata_1MHz),
      .coeff_rdbk_1MHz(rdbk1),
      .coeff_wr_en_2_4MHz(coeff_wr_en_2_4MHz), .coeff_wdata_2_4MHz(coeff_wdata_2_4MHz),
      .coeff_rdbk_2_4MHz(rdbk2),
      .busy(busy), .done(done), .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // notch filters: capture the bank on their strobe, readback word 2 optionally forced to 0
   always @(posedge clk) begin
      if (coeff_wr_en_1MHz)   fb1 <= coeff_wdata_1MHz;
      if (coeff_wr_en_2_4MHz) fb2 <= coeff_wdata_2_4MHz;
   end
   assign rdbk1 = corrupt2 ? (fb1 & ~W2_MASK) : fb1;
   assign rdbk2 = corrupt2 ? (fb2 & ~W2_MASK) : fb2;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BANK-1:0] bank_m(input bit s);
      logic [BANK-1:0] b;
      for (int i = 0; i < D; i++) b[i*W +: W] = sh_m[s][i];
      return b;
   endfunction

   task automatic reset_model();
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < D; i++) sh_m[s][i] = '0;
         mk_m[s] = '0;
      end
      err_m = '0;
   endtask

   task automatic send_word(input bit sel, input int unsigned idx, input logic [W-1:0] data,
                            input bit last, output bit commit);
      int unsigned w = 0;
      while (!cfg_ready && w < 200) begin
         tick();
         w++;
      end
      check_val("ready_wait", cfg_ready, 1);
      cfg_valid = 1'b1; cfg_sel = sel; cfg_idx = idx[2:0]; cfg_data = data; cfg_last = last;
      sample_valid = 1'($urandom_range(0, 1));
      commit = 1'b0;
      if (idx < D) begin
         sh_m[sel][idx] = data;
         mk_m[sel][idx] = 1'b1;
         if (last) begin
            if (&mk_m[sel]) commit = 1'b1;
            else err_m[1] = 1'b1;
            mk_m[sel] = '0;
         end
      end else begin
         err_m[0] = 1'b1;
      end
      tick();
      cfg_valid = 1'b0; cfg_last = 1'b0; sample_valid = 1'b0;
   endtask

   // entered in cycle T+1 after the last word was accepted in cycle T
   task automatic observe_commit(input bit sel, input int unsigned gap, input bit corrupt);
      int unsigned last_k = (gap >= 64) ? 70 : gap + 6;
      int wr_hit = 0, wr_other = 0, done_hit = 0, wr_k = -1, done_k = -1;
      corrupt2 = corrupt;
      for (int unsigned k = 1; k <= last_k; k++) begin
         sample_valid = (k <= gap);
         if (k == 1) check_val("busy_gap", busy, 1);
         if (sel ? coeff_wr_en_2_4MHz : coeff_wr_en_1MHz) begin
            wr_hit++;
            wr_k = int'(k);
            check_val("wdata_commit", sel ? coeff_wdata_2_4MHz : coeff_wdata_1MHz, bank_m(sel));
         end
         if (sel ? coeff_wr_en_1MHz : coeff_wr_en_2_4MHz) wr_other++;
         if (done) begin
            done_hit++;
            done_k = int'(k);
         end
         if (gap >= 64 && k == 65) begin
            check_val("busy_abort", busy, 0);
            check_val("ready_abort", cfg_ready, 1);
         end
         tick();
      end
      sample_valid = 1'b0;
      corrupt2 = 1'b0;
      check_val("wr_other_cnt", wr_other, 0);
      if (gap >= 64) begin
         check_val("wr_abort_cnt", wr_hit, 0);
         check_val("done_abort_cnt", done_hit, 0);
         err_m[2] = 1'b1;
      end else begin
         check_val("wr_cnt", wr_hit, 1);
         check_val("wr_cycle", wr_k, gap + 2);
         check_val("done_cnt", done_hit, 1);
         check_val("done_cycle", done_k, gap + 4);
         if (corrupt && sh_m[sel][2] != '0) err_m[3] = 1'b1;
      end
      check_val("err_after_commit", err, err_m);
   endtask

   task automatic load_bank(input bit sel, input logic [W-1:0] d [D], input int unsigned gap,
                            input bit corrupt);
      bit c;
      for (int unsigned i = 0; i < D; i++) send_word(sel, i, d[i], i == D - 1, c);
      if (c) observe_commit(sel, gap, corrupt);
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      err_m = '0;
   endtask

   initial begin
      logic [W-1:0] rw [D];
      bit c;
      int wr_seen;
      reset_model();
      spec_w = '{20'h00100, 20'h3FF00, 20'h00100, 20'h3E000, 20'h1F000};

      repeat (3) tick();
      check_val("rst_ready", cfg_ready, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_err", err, 0);
      check_val("rst_wr", {coeff_wr_en_1MHz, coeff_wr_en_2_4MHz}, 0);
      check_val("rst_wdata1", coeff_wdata_1MHz, 0);
      check_val("rst_wdata2", coeff_wdata_2_4MHz, 0);
      rst = 1'b0;
      #1;
      check_val("ready_after_rst", cfg_ready, 1);
      tick();

      load_bank(1'b0, spec_w, 0, 1'b0);
      load_bank(1'b1, spec_w, 10, 1'b0);
      for (int i = 0; i < D; i++) rw[i] = W'($urandom);
      load_bank(1'b0, rw, 63, 1'b0);
      for (int i = 0; i < D; i++) rw[i] = W'($urandom);
      load_bank(1'b1, rw, 64, 1'b0);
      clear_err();

      for (int unsigned i = 0; i < 4; i++) send_word(1'b0, i, W'($urandom), i == 3, c);
      check_val("err_incomplete", err, err_m);
      check_val("busy_incomplete", busy, 0);
      send_word(1'b0, 6, W'($urandom), 1'b0, c);
      check_val("err_bad_idx", err, err_m);
      check_val("wdata_bad_idx", coeff_wdata_1MHz, bank_m(1'b0));
      send_word(1'b1, 7, W'($urandom), 1'b1, c);
      tick();
      check_val("busy_bad_last", busy, 0);
      clear_err();
      check_val("err_cleared", err, 0);

      load_bank(1'b0, spec_w, 0, 1'b1);
      err_clr = 1'b1;
      err_m = '0;
      send_word(1'b1, 5, W'($urandom), 1'b0, c);
      err_clr = 1'b0;
      check_val("err_clr_vs_new", err, err_m);
      clear_err();
      check_val("err_clr", err, 0);

      for (int unsigned i = 0; i < D; i++) send_word(1'b1, i, W'($urandom), i == D - 1, c);
      repeat (5) begin
         sample_valid = 1'b1;
         tick();
      end
      rst = 1'b1;
      sample_valid = 1'b0;
      tick();
      reset_model();
      check_val("midrst_busy", busy, 0);
      check_val("midrst_done", done, 0);
      check_val("midrst_err", err, 0);
      check_val("midrst_wr", {coeff_wr_en_1MHz, coeff_wr_en_2_4MHz}, 0);
      check_val("midrst_wdata1", coeff_wdata_1MHz, bank_m(1'b0));
      check_val("midrst_wdata2", coeff_wdata_2_4MHz, bank_m(1'b1));
      rst = 1'b0;
      wr_seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (coeff_wr_en_1MHz || coeff_wr_en_2_4MHz) wr_seen++;
         tick();
      end
      check_val("midrst_no_wr", wr_seen, 0);
      check_val("midrst_ready", cfg_ready, 1);

      for (int it = 0; it < 25; it++) begin
         bit s;
         int unsigned order [D];
         int unsigned n;
         int unsigned gaps [7];
         s = 1'($urandom_range(0, 1));
         gaps = '{0, 1, 2, 3, 7, 63, 64};
         for (int i = 0; i < D; i++) order[i] = i;
         for (int i = D - 1; i > 0; i--) begin
            int j;
            int unsigned t;
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
         end
         n = ($urandom_range(0, 5) == 0) ? D - 1 : D;
         c = 1'b0;
         for (int unsigned j = 0; j < n; j++) begin
            if ($urandom_range(0, 7) == 0) send_word(s, $urandom_range(5, 7), W'($urandom), 1'b0, c);
            if ($urandom_range(0, 5) == 0) send_word(s, order[j], W'($urandom), 1'b0, c);
            send_word(s, order[j], W'($urandom), j == n - 1, c);
         end
         if (c) observe_commit(s, gaps[$urandom_range(0, 6)], $urandom_range(0, 3) == 0);
         check_val("rand_err", err, err_m);
         check_val("rand_wdata1", coeff_wdata_1MHz, bank_m(1'b0));
         check_val("rand_wdata2", coeff_wdata_2_4MHz, bank_m(1'b1));
         if ($urandom_range(0, 1) == 1) clear_err();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/iir_coeff_loader.md
Name: iir_coeff_loader

Overview:
- Writer side of the notch-chain coefficient port. Accepts coefficient words one at a time over a valid/ready config stream and holds them in per-filter shadow banks.
- Commits a complete bank to the 1 MHz or 2.4 MHz notch with a single write-enable pulse. The pulse is issued only in a cycle with no sample entering the chain.
- Reads the filter's coefficient readback after the commit and flags any mismatch.
- Sits between the register/config front end and the IIR chain.

Parameters:
- COEFF_WIDTH, 20, coefficient word width (signed).
- NUM_COEFF_DEPTH, 3, numerator coefficients per filter.
- DEN_COEFF_DEPTH, 2, denominator coefficients per filter.
- COEFF_DEPTH, NUM_COEFF_DEPTH+DEN_COEFF_DEPTH, words per bank.
- IDX_WIDTH, 3, width of cfg_idx; must be ≥ clog2(COEFF_DEPTH).
- GAP_TIMEOUT, 64, maximum WAIT_GAP cycles before abort.
- VERIFY_LAT, 1, cycles from write-enable pulse to valid readback.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  loader can accept a word
- cfg_sel  in  1  target filter: 0 = 1 MHz, 1 = 2.4 MHz
- cfg_idx  in  IDX_WIDTH  coefficient index
- cfg_data  in  COEFF_WIDTH  signed coefficient
- cfg_last  in  1  this word ends the bank; commit follows
- sample_valid  in  1  copy of the chain's input valid
- coeff_wr_en_1MHz  out  1  write strobe to 1 MHz notch
- coeff_wdata_1MHz  out  COEFF_WIDTH x COEFF_DEPTH  shadow bank for 1 MHz
- coeff_rdbk_1MHz  in  COEFF_WIDTH x COEFF_DEPTH  readback from 1 MHz notch
- coeff_wr_en_2_4MHz  out  1  write strobe to 2.4 MHz notch
- coeff_wdata_2_4MHz  out  COEFF_WIDTH x COEFF_DEPTH  shadow bank for 2.4 MHz
- coeff_rdbk_2_4MHz  in  COEFF_WIDTH x COEFF_DEPTH  readback from 2.4 MHz notch
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when a commit and its verify finish
- err  out  4  sticky flags: [0] bad index, [1] incomplete bank, [2] gap timeout, [3] verify mismatch
- err_clr  in  1  clears err

Behaviour:
- Single clock domain. rst is synchronous and active-high.
- Reset values: state IDLE; all shadow entries 0; both load masks 0; both wr_en outputs 0; done 0; busy 0; err 0; cfg_ready 0 while rst is high, 1 in the first cycle after.
- coeff_wdata_* are driven continuously from the shadow banks. Filters capture them only on their wr_en.
- Handshake: a word transfers when cfg_valid && cfg_ready. cfg_ready is 1 only in IDLE.
- IDLE, word accepted with cfg_idx < COEFF_DEPTH:
  - shadow[cfg_sel][cfg_idx] <= cfg_data;
  - mask[cfg_sel][cfg_idx] <= 1;
  - rewriting an index overwrites it.
- IDLE, word accepted with cfg_idx ≥ COEFF_DEPTH: data dropped, err[0] set, mask unchanged. If cfg_last is also set, state stays IDLE.
- IDLE, cfg_last accepted with a valid index: evaluate the target mask including this word.
  - All ones: go to WAIT_GAP, latch target = cfg_sel, clear the gap counter.
  - Otherwise: set err[1], clear that filter's mask, stay IDLE.
- WAIT_GAP:
  - sample_valid == 0 → COMMIT next cycle.
  - sample_valid == 1 → increment the counter.
  - Counter reaches GAP_TIMEOUT → set err[2], clear target mask, go to IDLE, no strobe issued.
- COMMIT (exactly 1 cycle): coeff_wr_en_<target> = 1; the other wr_en stays 0. Clear target mask. Go to VERIFY with counter = 0.
- VERIFY:
  - Count VERIFY_LAT cycles.
  - In the last cycle, compare coeff_rdbk_<target> to the shadow bank; any word differing sets err[3].
  - Next cycle: done = 1, state IDLE.
- Latency: cfg_last accepted in cycle T with sample_valid low at T+1 → wr_en at T+2 → done at T+3+VERIFY_LAT.
- Shadow banks are retained across commits and aborts. Only the masks are cleared.
- err bits are sticky. err_clr zeroes them; a new error raised in the same cycle as err_clr wins and stays set.
- rst mid-operation (any state): return to IDLE with reset values. No wr_en is issued after the reset cycle.

Test Plan:
- 5 words idx 0..4 = 0x00100, 0x3FF00, 0x00100, 0x3E000, 0x1F000, sel=0, last on idx 4, sample_valid=0 → coeff_wr_en_1MHz high exactly at T+2; coeff_wdata_1MHz matches; readback equal → done at T+4; err=0.
- Same load with sel=1 and sample_valid held 1 for 10 cycles → wr_en_2_4MHz at T+12; coeff_wr_en_1MHz never asserts.
- sample_valid held 1 for 64+ cycles → err[2]=1; no wr_en; busy drops; cfg_ready=1.
- Write idx 0..3 only, then last on idx 3 → err[1]=1; no wr_en. Separately, idx 6 write → err[0]=1 and shadow unchanged.
- Readback word 2 forced to 0 during VERIFY → err[3]=1 with done still pulsing. Then err_clr → err=0.
- rst asserted in WAIT_GAP → no wr_en ever; all outputs at reset values the next cycle.
